// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: response FSM states,
// requester ids and grant vector layout.
package mem_arbiter_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned GNT_IF     = 0;
    localparam int unsigned GNT_LS     = 1;
    localparam int unsigned STAT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_LS = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester that was not granted last wins
// a conflict. Purely combinational.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_e            last,
    output logic [NUM_REQ-1:0] gnt_c
);

    // One-hot grant: LS wins a tie only when IF was granted last
    always_comb begin
        gnt_c = '0;
        if (req[GNT_LS] && (!req[GNT_IF] || (last == REQ_IF))) begin
            gnt_c[GNT_LS] = 1'b1;
        end else if (req[GNT_IF]) begin
            gnt_c[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// synchronous single-port RAM with 1-cycle read latency.
// Optional macro MEM_ARBITER_STATS_EN adds saturating grant/conflict counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned CPU_WIDTH = 32,
    parameter int unsigned RAM_WIDTH = 31
) (
    input  logic                   clk,
    input  logic                   a_reset_n,
    input  logic                   if_req_valid,
    output logic                   if_req_ready,
    input  logic [RAM_WIDTH-1:0]   if_addr,
    output logic                   if_rsp_valid,
    output logic [CPU_WIDTH-1:0]   if_rdata,
    input  logic                   ls_req_valid,
    output logic                   ls_req_ready,
    input  logic [RAM_WIDTH-1:0]   ls_addr,
    input  logic                   ls_we,
    input  logic [CPU_WIDTH-1:0]   ls_wdata,
    input  logic [CPU_WIDTH/8-1:0] ls_be,
    output logic                   ls_rsp_valid,
    output logic [CPU_WIDTH-1:0]   ls_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [RAM_WIDTH-1:0]   mem_addr,
    output logic [CPU_WIDTH-1:0]   mem_wdata,
    output logic [CPU_WIDTH/8-1:0] mem_be,
    input  logic [CPU_WIDTH-1:0]   mem_rdata
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]  stat_if_grants,
    output logic [STAT_WIDTH-1:0]  stat_ls_grants,
    output logic [STAT_WIDTH-1:0]  stat_conflicts
`endif
);

    localparam int unsigned BE_WIDTH = CPU_WIDTH / 8;

    logic [NUM_REQ-1:0] req_c;
    logic [NUM_REQ-1:0] gnt_c;
    state_e             state_q, state_d;
    req_id_e            last_q, last_d;
    logic               rsp_rd_q, rsp_rd_d;

    // Requests are masked while reset is asserted so ready and mem_* drop at once
    assign req_c = {ls_req_valid, if_req_valid} & {NUM_REQ{a_reset_n}};

    rr_arb2 u_arb (
        .req   (req_c),
        .last  (last_q),
        .gnt_c (gnt_c)
    );

    // Response owner, last-granted pointer and read/write flag of the response
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q  <= IDLE;
            last_q   <= REQ_IF;
            rsp_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rsp_rd_q <= rsp_rd_d;
        end
    end

    // Next state from this cycle's grant; RAM muxing and response steering
    always_comb begin
        state_d      = IDLE;
        last_d       = last_q;
        rsp_rd_d     = 1'b0;
        if_req_ready = gnt_c[GNT_IF];
        ls_req_ready = gnt_c[GNT_LS];
        mem_en       = |gnt_c;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = '0;
        if_rsp_valid = (state_q == RSP_IF);
        ls_rsp_valid = (state_q == RSP_LS);
        if_rdata     = '0;
        ls_rdata     = '0;

        if (gnt_c[GNT_IF]) begin
            state_d  = RSP_IF;
            last_d   = REQ_IF;
            rsp_rd_d = 1'b1;
            mem_addr = if_addr;
        end else if (gnt_c[GNT_LS]) begin
            state_d   = RSP_LS;
            last_d    = REQ_LS;
            rsp_rd_d  = !ls_we;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_be    = BE_WIDTH'(ls_be);
        end

        if ((state_q == RSP_IF) && rsp_rd_q) begin
            if_rdata = mem_rdata;
        end
        if ((state_q == RSP_LS) && rsp_rd_q) begin
            ls_rdata = mem_rdata;
        end
    end

`ifdef MEM_ARBITER_STATS_EN
    // Saturating per-port accept counters and both-valid conflict counter
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            stat_if_grants <= '0;
            stat_ls_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (gnt_c[GNT_IF] && (stat_if_grants != '1)) begin
                stat_if_grants <= stat_if_grants + STAT_WIDTH'(1);
            end
            if (gnt_c[GNT_LS] && (stat_ls_grants != '1)) begin
                stat_ls_grants <= stat_ls_grants + STAT_WIDTH'(1);
            end
            if ((&req_c) && (stat_conflicts != '1)) begin
                stat_conflicts <= stat_conflicts + STAT_WIDTH'(1);
            end
        end
    end
`else
    // Statistics disabled: no counters, arbitration unchanged
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a request-level reference model predicts
// grants, RAM-side values and responses; a monitor checks responses.
// Define MEM_ARBITER_STATS_EN for both RTL and bench to check the counters.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        a_reset_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [30:0] if_addr;
    logic [31:0] if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
    logic [30:0] ls_addr;
    logic [31:0] ls_wdata, ls_rdata;
    logic [3:0]  ls_be;
    logic        mem_en, mem_we;
    logic [30:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] stat_if_grants, stat_ls_grants, stat_conflicts;
`endif

    mem_arbiter #(.CPU_WIDTH(32), .RAM_WIDTH(31)) dut (
        .clk          (clk),
        .a_reset_n    (a_reset_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rdata     (if_rdata),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_addr      (ls_addr),
        .ls_we        (ls_we),
        .ls_wdata     (ls_wdata),
        .ls_be        (ls_be),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rdata     (ls_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_rdata    (mem_rdata)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_ls_grants (stat_ls_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          port;   // 0 = IF, 1 = LS
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          last_ls = 1'b0;   // model pointer: 1 when LS was granted last
    bit          if_acc  = 1'b0;
    bit          ls_acc  = 1'b0;
    logic [31:0] ram       [64];   // RAM device behind the arbiter
    logic [31:0] model_mem [64];   // reference contents seen by requesters

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with 1-cycle read latency; rdata is junk when not reading
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= $urandom;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr[5:0]];
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // Request-side model: predict grant and RAM pins, queue the response
    always @(negedge clk) begin
        logic exp_if, exp_ls;
        rsp_t e;
        if (!a_reset_n) begin
            last_ls = 1'b0;
            if_acc  = 1'b0;
            ls_acc  = 1'b0;
            chk("rst_if_ready", if_req_ready, 0);
            chk("rst_ls_ready", ls_req_ready, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_pins", {mem_we, mem_addr, mem_be}, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end else begin
            if (if_req_valid && ls_req_valid) begin
                exp_ls = !last_ls;
                exp_if = last_ls;
            end else begin
                exp_if = if_req_valid;
                exp_ls = ls_req_valid;
            end
            chk("if_ready", if_req_ready, exp_if);
            chk("ls_ready", ls_req_ready, exp_ls);
            chk("mem_en", mem_en, exp_if | exp_ls);
            chk("mem_we", mem_we, exp_ls & ls_we);
            chk("mem_addr", mem_addr, exp_if ? if_addr : (exp_ls ? ls_addr : 31'd0));
            chk("mem_wdata", mem_wdata, exp_ls ? ls_wdata : 32'd0);
            chk("mem_be", mem_be, exp_ls ? ls_be : 4'd0);
            if_acc = exp_if;
            ls_acc = exp_ls;
            if (exp_if) begin
                last_ls = 1'b0;
                e.due = cyc + 1; e.port = 1'b0; e.data = model_mem[if_addr[5:0]];
                sb.push_back(e);
            end else if (exp_ls) begin
                last_ls = 1'b1;
                e.due = cyc + 1; e.port = 1'b1;
                e.data = ls_we ? 32'd0 : model_mem[ls_addr[5:0]];
                sb.push_back(e);
                if (ls_we)
                    for (int b = 0; b < 4; b++)
                        if (ls_be[b]) model_mem[ls_addr[5:0]][8*b +: 8] = ls_wdata[8*b +: 8];
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response is due
    always @(negedge clk) begin
        rsp_t e;
        if (!a_reset_n) begin
            sb.delete();
            chk("rst_rsp_valid", {if_rsp_valid, ls_rsp_valid}, 0);
            chk("rst_rdata", {if_rdata, ls_rdata}, 0);
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                chk("rsp_missing", 0, 1);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("if_rsp_valid", if_rsp_valid, e.port == 1'b0);
                chk("ls_rsp_valid", ls_rsp_valid, e.port == 1'b1);
                chk("if_rdata", if_rdata, (e.port == 1'b0) ? e.data : 32'd0);
                chk("ls_rdata", ls_rdata, (e.port == 1'b1) ? e.data : 32'd0);
            end else begin
                chk("idle_rsp_valid", {if_rsp_valid, ls_rsp_valid}, 0);
                chk("idle_rdata", {if_rdata, ls_rdata}, 0);
            end
        end
    end

    task automatic clear_inputs();
        if_req_valid = 0; if_addr = '0;
        ls_req_valid = 0; ls_addr = '0; ls_we = 0; ls_wdata = '0; ls_be = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        a_reset_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 a_reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_if, n_ls;
        for (int i = 0; i < 64; i++) begin
            ram[i] = 32'h0; model_mem[i] = 32'h0;
        end
        ram[16] = 32'hDEADBEEF; model_mem[16] = 32'hDEADBEEF;
        mem_rdata = '0;
        do_reset();

        // First conflict after reset: LS first, then IF
        if_req_valid = 1; if_addr = 31'd3;
        ls_req_valid = 1; ls_addr = 31'd4; ls_we = 0;
        @(negedge clk);
        chk("first_conflict_ls", {ls_req_ready, if_req_ready}, 2'b10);
        next_cycle(); ls_req_valid = 0;
        @(negedge clk);
        chk("second_grant_if", if_req_ready, 1);
        chk("first_rsp_ls", ls_rsp_valid, 1);
        next_cycle(); if_req_valid = 0;
        @(negedge clk);
        chk("second_rsp_if", if_rsp_valid, 1);
        repeat (2) next_cycle();

        // Fetch-only read
        if_req_valid = 1; if_addr = 31'h10;
        @(negedge clk);
        chk("fetch_ready", if_req_ready, 1);
        next_cycle(); if_req_valid = 0;
        @(negedge clk);
        chk("fetch_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b10);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        next_cycle();

        // Byte-masked write
        ls_req_valid = 1; ls_we = 1; ls_addr = 31'h20; ls_wdata = 32'h55AA00FF; ls_be = 4'b0101;
        @(negedge clk);
        chk("write_we_be", {mem_we, mem_be}, 5'b1_0101);
        next_cycle(); clear_inputs();
        @(negedge clk);
        chk("write_rsp", ls_rsp_valid, 1);
        chk("write_rdata", ls_rdata, 0);
        next_cycle();
        ls_req_valid = 1; ls_addr = 31'h20;
        next_cycle(); clear_inputs();
        @(negedge clk);
        chk("readback_merged", ls_rdata, 32'h00AA00FF);
        next_cycle();

        // Reset during the response cycle drops the response
        if_req_valid = 1; if_addr = 31'h10;
        next_cycle();
        a_reset_n = 0;
        #1;
        chk("midrst_rsp", {if_rsp_valid, if_req_ready, mem_en}, 0);
        chk("midrst_rdata", if_rdata, 0);
        clear_inputs();
        @(posedge clk); #1 a_reset_n = 1;
        repeat (3) next_cycle();

        // Sustained conflict from reset: strict alternation, LS first
        do_reset();
        if_req_valid = 1; if_addr = 31'd1;
        ls_req_valid = 1; ls_addr = 31'd2; ls_we = 0;
        n_if = 0; n_ls = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("alt_grant", {ls_req_ready, if_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            n_if += int'(if_req_ready);
            n_ls += int'(ls_req_ready);
            next_cycle();
        end
        clear_inputs();
        chk("alt_if_count", n_if, 5);
        chk("alt_ls_count", n_ls, 5);
`ifdef MEM_ARBITER_STATS_EN
        @(negedge clk);
        chk("stat_if", stat_if_grants, 5);
        chk("stat_ls", stat_ls_grants, 5);
        chk("stat_conf", stat_conflicts, 10);
        next_cycle();
`endif
        next_cycle();

        // Random traffic; unaccepted requests are held stable
        for (int i = 0; i < 400; i++) begin
            if (!(if_req_valid && !if_acc)) begin
                if_req_valid = ($urandom_range(0, 9) < 6);
                if_addr      = 31'($urandom_range(0, 63));
            end
            if (!(ls_req_valid && !ls_acc)) begin
                ls_req_valid = ($urandom_range(0, 9) < 6);
                ls_addr      = 31'($urandom_range(0, 63));
                ls_we        = 1'($urandom_range(0, 1));
                ls_wdata     = $urandom;
                ls_be        = 4'($urandom_range(0, 15));
            end
            next_cycle();
        end
        clear_inputs();
        repeat (3) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
